// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings for the multiply/divide sequencer
package mdu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    localparam logic OP_MULTU = 1'b0;
    localparam logic OP_DIVU  = 1'b1;

endpackage

// File: rtl/mdu_sequencer_if.sv
// rtl/mdu_sequencer_if.sv - request/result bundle between control unit and sequencer
interface mdu_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/alu32.sv
// rtl/alu32.sv - 32-bit MIPS-lite ALU (and/or/add/sub/slt); zero flag not needed by this client
module alu32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [2:0]  gin_i,
    output logic [31:0] y_o
);

    // Select the operation by the MIPS-lite function encoding
    always_comb begin
        y_o = '0;
        case (gin_i)
            3'b000:  y_o = a_i & b_i;
            3'b001:  y_o = a_i | b_i;
            3'b010:  y_o = a_i + b_i;
            3'b110:  y_o = a_i - b_i;
            3'b111:  y_o = {31'b0, $signed(a_i) < $signed(b_i)};
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - iterative unsigned MULTU/DIVU sequencer driving one alu32
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    mdu_sequencer_if.slave       bus
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               op_q;
    logic [WIDTH-1:0]   breg_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               dbz_q;

    logic               busy_d;
    logic               done_d;
    logic               accept;
    logic               zero_div;

    logic [WIDTH-1:0]   div_r;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_y;
    logic [2:0]         alu_gin;
    logic               mul_c;
    logic               div_bw;
    logic [WIDTH-1:0]   hi_step;
    logic [WIDTH-1:0]   lo_step;

    assign accept   = (state_q == S_IDLE) && bus.start;
    assign zero_div = (bus.op == OP_DIVU) && (bus.b == '0);

    // ALU operand/function selection follows the latched op, not the live request
    always_comb begin
        div_r   = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        alu_a   = (op_q == OP_DIVU) ? div_r : hi_q;
        alu_gin = (op_q == OP_DIVU) ? ALU_SUB : ALU_ADD;
    end

    alu32 u_alu (
        .a_i   (alu_a),
        .b_i   (breg_q),
        .gin_i (alu_gin),
        .y_o   (alu_y)
    );

    // The ALU has no carry output, so carry/borrow come from operand and result MSBs
    always_comb begin
        mul_c  = (hi_q[WIDTH-1] & breg_q[WIDTH-1])
               | ((hi_q[WIDTH-1] | breg_q[WIDTH-1]) & ~alu_y[WIDTH-1]);
        div_bw = (~div_r[WIDTH-1] & breg_q[WIDTH-1])
               | ((~div_r[WIDTH-1] | breg_q[WIDTH-1]) & alu_y[WIDTH-1]);
    end

    // One shift-add or restoring-divide step; hi[31] before the shift is the 33rd remainder bit
    always_comb begin
        hi_step = hi_q;
        lo_step = lo_q;
        if (op_q == OP_MULTU) begin
            if (lo_q[0]) begin
                hi_step = {mul_c, alu_y[WIDTH-1:1]};
                lo_step = {alu_y[0], lo_q[WIDTH-1:1]};
            end else begin
                hi_step = {1'b0, hi_q[WIDTH-1:1]};
                lo_step = {hi_q[0], lo_q[WIDTH-1:1]};
            end
        end else begin
            if (hi_q[WIDTH-1] | ~div_bw) begin
                hi_step = alu_y;
                lo_step = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_step = div_r;
                lo_step = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and status outputs
    always_comb begin
        state_d = state_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = zero_div ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy_d = 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers: load on accept, step every RUN cycle, hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            op_q   <= OP_MULTU;
            breg_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            dbz_q  <= 1'b0;
        end else if (accept) begin
            op_q   <= bus.op;
            breg_q <= bus.b;
            cnt_q  <= '0;
            if (zero_div) begin
                hi_q  <= bus.a;
                lo_q  <= '1;
                dbz_q <= 1'b1;
            end else begin
                hi_q  <= '0;
                lo_q  <= bus.a;
                dbz_q <= 1'b0;
            end
        end else if (state_q == S_RUN) begin
            hi_q  <= hi_step;
            lo_q  <= lo_step;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.busy        = busy_d;
    assign bus.done        = done_d;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule
